// File: rtl/gen_seq_ctrl.sv
// gen_seq_ctrl
//   Transaction controller for the LFSR generator -> FIFO -> consumer path.
//   A start pulse enables the generator until burst_len words have been
//   written into the FIFO, then drains the same number of words through the
//   FIFO read port and pulses done. Supports abort (with FIFO clear),
//   occupancy bookkeeping and a sticky overflow flag.
//
// Ports
//   clk        : system clock (shared with generator and FIFO)
//   rst_n      : synchronous active-low reset
//   start      : single-cycle transaction request, sampled in IDLE only
//   abort      : synchronous abort, ignored in IDLE
//   burst_len  : words per transaction, latched on an accepted start
//   full/empty : FIFO status flags
//   wrreq_mon  : generator wrreq, counts actual writes
//   rd_ready   : consumer can take a word this cycle
//   ENgen      : generator enable
//   ENwrk      : generator work enable
//   rdreq      : FIFO read request
//   fifo_sclr  : one-cycle FIFO clear following an abort
//   busy       : high in every state except IDLE
//   done       : one-cycle completion pulse
//   ovf_err    : sticky, a write was seen while full was high
//   wr_cnt     : words written in the current transaction
//   rd_cnt     : words read in the current transaction
module gen_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             full,
  input  logic             empty,
  input  logic             wrreq_mon,
  input  logic             rd_ready,
  output logic             ENgen,
  output logic             ENwrk,
  output logic             rdreq,
  output logic             fifo_sclr,
  output logic             busy,
  output logic             done,
  output logic             ovf_err,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_len_q;
  logic [CNT_W-1:0] r_iss_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_ovf_err;
  logic             r_fifo_sclr;

  logic             w_abort_act;
  logic             w_engen;
  logic             w_enwrk;
  logic             w_rdreq;
  logic             w_done;
  logic [CNT_W-1:0] w_iss_nxt;
  logic [CNT_W-1:0] w_rd_nxt;

  // Enables and rdreq react to full/empty/rd_ready in the same cycle, so they
  // are decoded from registered state rather than registered themselves.
  // Abort gates them off in the abort cycle itself.
  always_comb begin
    w_abort_act = abort && (r_state != S_IDLE);
    w_engen     = (r_state == S_FILL) && (r_iss_cnt < r_len_q) && !full && !abort;
    w_enwrk     = ((r_state == S_FILL) || (r_state == S_FLUSH)) && !abort;
    w_rdreq     = (r_state == S_DRAIN) && !empty && rd_ready &&
                  (r_rd_cnt < r_len_q) && !abort;
    w_done      = (r_state == S_DONE) && !abort;
    w_iss_nxt   = r_iss_cnt + CNT_W'(w_engen);
    w_rd_nxt    = r_rd_cnt + CNT_W'(w_rdreq);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len_q     <= '0;
      r_iss_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_ovf_err   <= 1'b0;
      r_fifo_sclr <= 1'b0;
    end else begin
      r_fifo_sclr <= 1'b0;

      // Overflow watch runs in every state, including stray IDLE writes.
      if (wrreq_mon && full)
        r_ovf_err <= 1'b1;

      if (wrreq_mon && ((r_state == S_FILL) || (r_state == S_FLUSH)))
        r_wr_cnt <= r_wr_cnt + 1'b1;

      if (w_abort_act) begin
        r_state     <= S_IDLE;
        r_fifo_sclr <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_len_q   <= burst_len;
              r_iss_cnt <= '0;
              r_wr_cnt  <= '0;
              r_rd_cnt  <= '0;
              r_ovf_err <= 1'b0;
              r_state   <= (burst_len == '0) ? S_DONE : S_FILL;
            end
          end
          S_FILL: begin
            r_iss_cnt <= w_iss_nxt;
            // Leave on the cycle the last word is issued; FLUSH absorbs the
            // generator's one-cycle enable-to-write latency.
            if (w_iss_nxt == r_len_q)
              r_state <= S_FLUSH;
          end
          S_FLUSH: begin
            if (r_wr_cnt == r_len_q)
              r_state <= S_DRAIN;
          end
          S_DRAIN: begin
            r_rd_cnt <= w_rd_nxt;
            if (w_rd_nxt == r_len_q)
              r_state <= S_DONE;
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ENgen     = w_engen;
  assign ENwrk     = w_enwrk;
  assign rdreq     = w_rdreq;
  assign done      = w_done;
  assign busy      = (r_state != S_IDLE);
  assign fifo_sclr = r_fifo_sclr;
  assign ovf_err   = r_ovf_err;
  assign wr_cnt    = r_wr_cnt;
  assign rd_cnt    = r_rd_cnt;

endmodule

// File: tb/tb_gen_seq_ctrl.sv
module tb_gen_seq_ctrl;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, full, empty, wrreq_mon, rd_ready;
  logic [CNT_W-1:0] burst_len;
  logic             ENgen, ENwrk, rdreq, fifo_sclr, busy, done, ovf_err;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;

  always #5 clk = ~clk;

  gen_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .burst_len(burst_len), .full(full), .empty(empty),
    .wrreq_mon(wrreq_mon), .rd_ready(rd_ready),
    .ENgen(ENgen), .ENwrk(ENwrk), .rdreq(rdreq), .fifo_sclr(fifo_sclr),
    .busy(busy), .done(done), .ovf_err(ovf_err),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one transaction.
  typedef enum int { K_DONE, K_ABORT, K_RST } kind_e;
  typedef struct {
    kind_e kind;
    int    len;
    int    lat;      // start cycle -> done cycle, -1 when stalls make it unknown
    bit    ovf;
    bit    chk_cnt;
  } exp_t;
  exp_t exp_q[$];

  // Environment model: generator writes one cycle after each enable (delayed
  // while full unless an overflow is injected); FIFO occupancy gives empty.
  int   pend = 0;
  int   occ  = 0;
  bit   force_wr = 0;
  logic last_busy;

  task automatic step();
    logic en_s, rq_s, wr_s, sclr_s;
    empty     = (occ == 0);
    wrreq_mon = force_wr || (pend > 0 && !full);
    #1;
    en_s = ENgen; rq_s = rdreq; wr_s = wrreq_mon; sclr_s = fifo_sclr;
    last_busy = busy;
    @(posedge clk);
    if (!rst_n) begin
      pend = 0; occ = 0;
    end else begin
      if (wr_s && pend > 0) pend--;
      if (en_s) pend++;
      if (wr_s) occ++;
      if (rq_s && occ > 0) occ--;
      if (sclr_s) occ = 0;
    end
    @(negedge clk);
  endtask

  task automatic run_txn(input int len, input int full_lo, input int full_hi,
                         input int rd_mode, input int abort_at, input int ovf_at,
                         input int rst_at);
    exp_t e;
    bit   fin;
    e.len     = len;
    e.ovf     = (ovf_at >= 0);
    e.chk_cnt = (len != 0);
    e.kind    = (rst_at >= 0) ? K_RST : (abort_at > 0) ? K_ABORT : K_DONE;
    e.lat     = (len == 0) ? 1 :
                (full_lo < 0 && rd_mode == 0 && ovf_at < 0) ? 2*len + 3 : -1;
    exp_q.push_back(e);
    burst_len = CNT_W'(len);
    fin = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      start    = (cyc == 0);
      abort    = (cyc == abort_at);
      rst_n    = (cyc == rst_at) ? 1'b0 : 1'b1;
      full     = (full_lo >= 0 && cyc >= full_lo && cyc <= full_hi) || (cyc == ovf_at);
      force_wr = (cyc == ovf_at);
      case (rd_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      if (cyc > 0 && !last_busy) fin = 1;
    end
    start = 0; abort = 0; full = 0; force_wr = 0; rst_n = 1; rd_ready = 1;
    check("txn_terminates", fin, 1);
    step();
    step();
  endtask

  // Monitor: rule checks every cycle, scoreboard pop on done/fifo_sclr/reset exit.
  bit prev_rst_low = 1, prev_abort_busy = 0, prev_busy = 0;
  int en_cnt = 0, rq_cnt = 0, lat_cnt = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_rst_low = 1; prev_abort_busy = 0; prev_busy = 0;
        continue;
      end
      if (prev_rst_low) begin
        prev_rst_low = 0;
        check("sb_has_entry_rst", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("kind_rst", e.kind, K_RST);
          check("rst_ctrl_outs", {ENgen, ENwrk, rdreq, fifo_sclr, busy, done, ovf_err}, 0);
          check("rst_wr_cnt", wr_cnt, 0);
          check("rst_rd_cnt", rd_cnt, 0);
        end
      end
      if (busy && !prev_busy) begin
        en_cnt = 0; rq_cnt = 0; lat_cnt = 0;
      end
      if (busy) lat_cnt++;
      en_cnt += int'(ENgen);
      rq_cnt += int'(rdreq);
      if (ENgen) check("engen_while_full", full, 0);
      if (rdreq) check("rdreq_ready_nonempty", {rd_ready, empty}, 2'b10);
      if (abort && busy) check("abort_cycle_outs_off", {ENgen, ENwrk, rdreq, done}, 0);
      check("fifo_sclr_after_abort", fifo_sclr, prev_abort_busy);
      if (done || fifo_sclr) begin
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (done) begin
            check("kind_done", e.kind, K_DONE);
            check("busy_at_done", busy, 1);
            check("engen_cycles", en_cnt, e.len);
            check("rdreq_cycles", rq_cnt, e.len);
            if (e.chk_cnt) begin
              check("wr_cnt_final", wr_cnt, e.len);
              check("rd_cnt_final", rd_cnt, e.len);
              check("ovf_err_at_done", ovf_err, e.ovf);
            end
            if (e.lat >= 0) check("start_to_done", lat_cnt, e.lat);
          end else begin
            check("kind_abort", e.kind, K_ABORT);
            check("busy_after_abort", busy, 0);
          end
        end
      end
      prev_abort_busy = abort && busy;
      prev_busy       = busy;
    end
  end

  initial begin
    logic [CNT_W-1:0] wr_before;
    exp_t             e;
    int len, lo, hi, mode, ab;
    rst_n = 0; start = 0; abort = 0; full = 0; rd_ready = 1;
    burst_len = '0; wrreq_mon = 0; empty = 1; last_busy = 0;
    e.kind = K_RST; e.len = 0; e.lat = -1; e.ovf = 0; e.chk_cnt = 0;
    exp_q.push_back(e);
    @(negedge clk);
    repeat (3) step();
    rst_n = 1;
    step();

    run_txn(5, -1, -1, 0, -1, -1, -1);   // nominal, done at cycle 13
    run_txn(0, -1, -1, 0, -1, -1, -1);   // zero length
    run_txn(8,  3,  6, 0, -1, -1, -1);   // full backpressure in FILL cycles 3..6
    run_txn(6, -1, -1, 1, -1, -1, -1);   // consumer stall 1,0,0,...
    run_txn(10, -1, -1, 0, 3, -1, -1);   // abort in 3rd FILL cycle
    run_txn(4, -1, -1, 0, -1, -1, -1);   // normal after abort
    run_txn(3, -1, -1, 0, 0, -1, -1);    // start+abort together in IDLE
    run_txn(4, -1, -1, 0, 11, -1, -1);   // abort in DONE suppresses done
    run_txn(6, -1, -1, 0, -1, 3, -1);    // overflow write during FILL

    // Stray write in IDLE with full: sets ovf_err, not counted.
    wr_before = wr_cnt;
    full = 1; force_wr = 1;
    step();
    full = 0; force_wr = 0;
    occ = 0;
    step();
    check("stray_sets_ovf", ovf_err, 1);
    check("stray_not_counted", wr_cnt, wr_before);
    run_txn(3, -1, -1, 0, -1, -1, -1);   // accepted start clears ovf_err

    run_txn(5, -1, -1, 0, -1, 3, 10);    // reset mid-DRAIN

    for (int i = 0; i < 25; i++) begin
      len  = int'($urandom_range(1, 20));
      mode = int'($urandom_range(0, 2));
      lo = -1; hi = -1; ab = -1;
      if ($urandom_range(0, 1) == 1) begin
        lo = int'($urandom_range(1, len));
        hi = lo + int'($urandom_range(0, 3));
      end
      if (mode == 0 && lo < 0 && $urandom_range(0, 3) == 0)
        ab = int'($urandom_range(1, 2*len + 3));
      run_txn(len, lo, hi, mode, ab, -1, -1);
    end

    step();
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/gen_seq_ctrl.md
# gen_seq_ctrl

Transaction controller for the LFSR generator → FIFO → consumer datapath. On a `start` pulse it enables the generator until exactly `burst_len` words have been written into the FIFO. It then drains the same number of words to the consumer through the FIFO read port and reports completion. It drives the generator's `ENgen`/`ENwrk` enables, issues FIFO `rdreq`, and also provides abort, occupancy bookkeeping and an overflow flag.

## Interface
- `CNT_W`, default 8: width of `burst_len` and of the internal and output word counters.
- `clk`  in  1  system clock, the same clock as the generator and FIFO.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle request to begin a transaction; sampled only in IDLE.
- `abort`  in  1  synchronous abort; has priority over everything except reset.
- `burst_len`  in  CNT_W  number of words in the transaction; latched on an accepted `start`.
- `full`  in  1  FIFO full flag.
- `empty`  in  1  FIFO empty flag.
- `wrreq_mon`  in  1  generator `wrreq` output, used to count actual writes.
- `rd_ready`  in  1  consumer can accept a word this cycle.
- `ENgen`  out  1  generator enable.
- `ENwrk`  out  1  generator work enable.
- `rdreq`  out  1  FIFO read request.
- `fifo_sclr`  out  1  single-cycle FIFO synchronous clear, issued on abort.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle completion pulse.
- `ovf_err`  out  1  sticky flag: a write was observed while `full` was high.
- `wr_cnt`  out  CNT_W  words written in the current transaction.
- `rd_cnt`  out  CNT_W  words read in the current transaction.

## Operation
- Registered state: `len_q`, `iss_cnt`, `wr_cnt`, `rd_cnt`, `ovf_err`, and the FSM state.
- States are IDLE, FILL, FLUSH, DRAIN, DONE.
- **IDLE**
  - `start`=1 and `burst_len`≠0: latch `len_q`, clear all counters, go to FILL.
  - `start`=1 and `burst_len`=0: go directly to DONE.
- **FILL**
  - `ENwrk`=1.
  - `ENgen` = (`iss_cnt` < `len_q`) && !`full`; this is combinational from registered state plus `full`.
  - `iss_cnt` increments every cycle `ENgen`=1. It predicts the generator's registered `wrreq` one cycle later.
  - When `iss_cnt` reaches `len_q`, go to FLUSH.
- **FLUSH**
  - `ENgen`=0, `ENwrk`=1.
  - Wait until `wr_cnt` equals `len_q`, then go to DRAIN. This absorbs the generator's one-cycle enable-to-write latency.
- **Write counting**: `wr_cnt` increments on every cycle with `wrreq_mon`=1, in FILL and FLUSH.
- **DRAIN**
  - `ENgen`=0, `ENwrk`=0.
  - `rdreq` = !`empty` && `rd_ready` && (`rd_cnt` < `len_q`).
  - `rd_cnt` increments on every cycle with `rdreq`=1.
  - When `rd_cnt` equals `len_q`, go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE. `wr_cnt` and `rd_cnt` hold their values until the next accepted `start`.
- **Abort** (in any non-IDLE state)
  - Go to IDLE next cycle and pulse `fifo_sclr` for one cycle.
  - `ENgen`, `ENwrk` and `rdreq` are forced to 0 in the abort cycle itself.
  - `done` is not pulsed.
  - In IDLE, `abort` is ignored.
- **Overflow**: `ovf_err` sets when `wrreq_mon` && `full`. It clears only on reset or on an accepted `start`.
- **Counter width**: all counters are CNT_W wide. `burst_len` covers 1..2^CNT_W−1, so counters never wrap inside a transaction.
- **Stray writes**: a `wrreq_mon` pulse in IDLE is ignored for counting, but it still sets `ovf_err` if `full` is high.

## Timing
- **Reset**: `rst_n`=0 at a rising edge forces the following values, overriding any transaction in progress:
  - state = IDLE;
  - all counters = 0;
  - `ovf_err`, `done`, `busy`, `ENgen`, `ENwrk`, `rdreq`, `fifo_sclr` = 0.
- **Start**: `start` at edge N gives `busy`=1 and `ENgen`=1 (if !`full`) in cycle N+1. The first `wrreq_mon` is expected in cycle N+2.
- **Full stall**: while `full`=1, `ENgen` drops in the same cycle and `iss_cnt` holds.
- **Best case latency**: `start` to `done` = `len_q` + 3 + `len_q` cycles, with the FIFO never full/empty-stalled and `rd_ready`=1.
- **Read latency**: `rdreq` is a request only. Data is consumed by the FIFO's read latency, outside this block.
- **Simultaneous events**:
  - `start` and `abort` together in IDLE: `start` wins.
  - `abort` in DONE: go to IDLE, and the `done` pulse for that cycle is suppressed.

## Test plan
- **Nominal**: `burst_len`=5, `full`=0, `rd_ready`=1, generator in loop.
  - `ENgen` is high 5 cycles and `wr_cnt`=5.
  - 5 `rdreq` pulses are issued and `done` pulses once at cycle 13 after `start`.
- **Zero length**: `burst_len`=0.
  - `done` pulses the cycle after `start` (while `busy`=1).
  - `ENgen` and `rdreq` never assert.
- **Full backpressure**: `burst_len`=8, `full` forced high for cycles 3–6 of FILL.
  - `ENgen`=0 during those cycles, `iss_cnt` holds.
  - `wr_cnt` still ends at 8, `ovf_err` stays 0.
- **Consumer stall**: in DRAIN, `rd_ready` toggles 1,0,0,1…
  - `rdreq` asserts only on `rd_ready`=1 cycles.
  - `rd_cnt` reaches `len_q` exactly and there is no extra `rdreq`.
- **Abort**: `abort` in the 3rd FILL cycle with `burst_len`=10.
  - Next cycle: IDLE, `fifo_sclr`=1 for 1 cycle, `busy`=0, no `done`.
  - A new `start` then completes normally.
- **Reset and overflow**
  - `wrreq_mon`=1 with `full`=1 sets `ovf_err`, which holds through DONE.
  - `rst_n`=0 mid-DRAIN clears every output to 0 at the next edge.
